// File: rtl/alu_seq_pkg.sv
// Shared types and constants for the add/sub/PADDSB/RED sequencer.
// Pure declarations: no latency, no flow control.
package alu_seq_pkg;

  typedef enum logic [1:0] {
    OP_ADD    = 2'b00,
    OP_SUB    = 2'b01,
    OP_PADDSB = 2'b10,
    OP_RED    = 2'b11
  } op_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_EXEC,
    ST_RED0,
    ST_RED1,
    ST_RED2,
    ST_RESP
  } state_e;

  localparam int FLAG_Z = 2;
  localparam int FLAG_V = 1;
  localparam int FLAG_N = 0;

  localparam logic [15:0] SAT_POS = 16'h7FFF;
  localparam logic [15:0] SAT_NEG = 16'h8000;

  function automatic logic [15:0] sext8(input logic [7:0] x);
    return {{8{x[7]}}, x};
  endfunction

endpackage

// File: rtl/alu_addsub_sequencer_shared_adder16.sv
// Combinational 16-bit adder with optional subtract and a 4x4-bit carry-isolated mode.
// Zero latency; no flow control.
module shared_adder16 (
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        sub,
  input  logic        nibble_mode,
  output logic [15:0] sum,
  output logic        ovf16,
  output logic [3:0]  nib_ovf
);

  logic [15:0] b_eff;
  logic [15:0] full_sum;
  logic [15:0] nib_sum;

  always_comb begin
    b_eff    = sub ? ~b : b;
    full_sum = a + b_eff + {15'd0, sub};
    nib_sum  = '0;
    nib_ovf  = '0;
    // Each nibble gets its own carry-in so the lanes never interact.
    for (int i = 0; i < 4; i++) begin
      nib_sum[4*i +: 4] = a[4*i +: 4] + b_eff[4*i +: 4] + {3'd0, sub};
      nib_ovf[i]        = (a[4*i+3] == b_eff[4*i+3]) && (nib_sum[4*i+3] != a[4*i+3]);
    end
    ovf16 = (a[15] == b_eff[15]) && (full_sum[15] != a[15]);
    sum   = nibble_mode ? nib_sum : full_sum;
  end

endmodule

// File: rtl/alu_addsub_sequencer.sv
// Multi-cycle ADD/SUB/PADDSB/RED controller sharing one adder; response 2 edges (ALU) or 4 edges (RED) after accept.
// One request in flight; result held in RESP until rsp_ready, req_ready only in IDLE.
module alu_addsub_sequencer
  import alu_seq_pkg::*;
#(
  parameter bit SAT_EN    = 1'b1,
  parameter bit RED_FLAGS = 1'b0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  req_op,
  input  logic [15:0] req_a,
  input  logic [15:0] req_b,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [15:0] rsp_result,
  output logic [2:0]  rsp_flags,
  output logic        busy
);

  state_e      state_q, state_d;
  op_e         op_q, op_d;
  logic [15:0] a_q, a_d, b_q, b_d, acc_q, acc_d, result_q, result_d;
  logic [2:0]  flags_q, flags_d;

  logic [15:0] add_a, add_b, add_sum, alu_res;
  logic        add_sub, add_nib, ovf16, alu_v;
  logic [3:0]  nib_ovf;

  always_comb begin
    add_a   = a_q;
    add_b   = b_q;
    add_sub = (op_q == OP_SUB);
    add_nib = (op_q == OP_PADDSB);
    case (state_q)
      ST_RED0: begin add_a = sext8(a_q[15:8]); add_b = sext8(a_q[7:0]); end
      ST_RED1: begin add_a = acc_q;            add_b = sext8(b_q[15:8]); end
      ST_RED2: begin add_a = acc_q;            add_b = sext8(b_q[7:0]);  end
      default: ;
    endcase
  end

  shared_adder16 u_adder (
    .a           (add_a),
    .b           (add_b),
    .sub         (add_sub),
    .nibble_mode (add_nib),
    .sum         (add_sum),
    .ovf16       (ovf16),
    .nib_ovf     (nib_ovf)
  );

  // Saturation keys off operand A's sign: on overflow both operand signs agree.
  always_comb begin
    alu_res = add_sum;
    alu_v   = add_nib ? |nib_ovf : ovf16;
    if (add_nib) begin
      for (int i = 0; i < 4; i++) begin
        if (nib_ovf[i]) alu_res[4*i +: 4] = a_q[4*i+3] ? 4'h8 : 4'h7;
      end
    end else if (SAT_EN && ovf16) begin
      alu_res = a_q[15] ? SAT_NEG : SAT_POS;
    end
  end

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    a_d      = a_q;
    b_d      = b_q;
    acc_d    = acc_q;
    result_d = result_q;
    flags_d  = flags_q;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          a_d     = req_a;
          b_d     = req_b;
          op_d    = op_e'(req_op);
          state_d = (op_e'(req_op) == OP_RED) ? ST_RED0 : ST_EXEC;
        end
      end
      ST_EXEC: begin
        result_d        = alu_res;
        flags_d[FLAG_Z] = (alu_res == 16'h0000);
        flags_d[FLAG_V] = alu_v;
        flags_d[FLAG_N] = alu_res[15];
        state_d         = ST_RESP;
      end
      ST_RED0: begin acc_d = add_sum; state_d = ST_RED1; end
      ST_RED1: begin acc_d = add_sum; state_d = ST_RED2; end
      ST_RED2: begin
        result_d        = add_sum;
        flags_d         = 3'b000;
        if (RED_FLAGS) begin
          flags_d[FLAG_Z] = (add_sum == 16'h0000);
          flags_d[FLAG_N] = add_sum[15];
        end
        state_d         = ST_RESP;
      end
      ST_RESP: begin
        if (rsp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      op_q     <= OP_ADD;
      a_q      <= '0;
      b_q      <= '0;
      acc_q    <= '0;
      result_q <= '0;
      flags_q  <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      acc_q    <= acc_d;
      result_q <= result_d;
      flags_q  <= flags_d;
    end
  end

  assign req_ready  = (state_q == ST_IDLE);
  assign busy       = (state_q != ST_IDLE);
  assign rsp_valid  = (state_q == ST_RESP);
  assign rsp_result = result_q;
  assign rsp_flags  = flags_q;

endmodule

// File: tb/tb_alu_addsub_sequencer.sv
// Scoreboard bench: two sequencers (saturating/no-RED-flags and wrapping/RED-flags) run in lockstep.
// Expected results are pushed at acceptance and checked by an independent response monitor.
module tb_alu_addsub_sequencer;

  logic        clk, rst_n;
  logic        req_valid, rsp_ready;
  logic [1:0]  req_op;
  logic [15:0] req_a, req_b;
  logic        req_ready, rsp_valid, busy;
  logic [15:0] rsp_result;
  logic [2:0]  rsp_flags;
  logic        alt_req_ready, alt_rsp_valid, alt_busy;
  logic [15:0] alt_rsp_result;
  logic [2:0]  alt_rsp_flags;

  alu_addsub_sequencer #(.SAT_EN(1'b1), .RED_FLAGS(1'b0)) u_dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_a(req_a), .req_b(req_b), .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready), .rsp_result(rsp_result), .rsp_flags(rsp_flags), .busy(busy)
  );

  alu_addsub_sequencer #(.SAT_EN(1'b0), .RED_FLAGS(1'b1)) u_alt (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(alt_req_ready),
    .req_op(req_op), .req_a(req_a), .req_b(req_b), .rsp_valid(alt_rsp_valid),
    .rsp_ready(rsp_ready), .rsp_result(alt_rsp_result), .rsp_flags(alt_rsp_flags), .busy(alt_busy)
  );

  typedef struct {
    logic [15:0] r0;
    logic [2:0]  f0;
    logic [15:0] r1;
    logic [2:0]  f1;
    int          lat;
    int          acc_cyc;
  } exp_t;

  typedef struct {
    logic [1:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] r0;
    logic [2:0]  f0;
    logic [15:0] r1;
    logic [2:0]  f1;
  } vec_t;

  exp_t q[$];
  exp_t mon_e;
  vec_t vecs[10];
  int   n_pass, n_total, cyc;
  logic prev_valid;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
  endtask

  // Monitor: latency counted in edges including the accepting one.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_valid = 1'b0;
    end else begin
      check("alt_valid_lockstep", {31'd0, alt_rsp_valid}, {31'd0, rsp_valid});
      if (rsp_valid && !prev_valid) begin
        check("rsp_unexpected", q.size(), (q.size() == 0) ? 1 : q.size());
        if (q.size() != 0) check("latency", cyc - q[0].acc_cyc + 1, q[0].lat);
      end
      if (rsp_valid && rsp_ready && q.size() != 0) begin
        mon_e = q.pop_front();
        check("result", {16'd0, rsp_result}, {16'd0, mon_e.r0});
        check("flags", {29'd0, rsp_flags}, {29'd0, mon_e.f0});
        check("alt_result", {16'd0, alt_rsp_result}, {16'd0, mon_e.r1});
        check("alt_flags", {29'd0, alt_rsp_flags}, {29'd0, mon_e.f1});
      end
      prev_valid = rsp_valid;
    end
  end

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic send(input logic [1:0] op, input logic [15:0] a, input logic [15:0] b,
                      input logic [15:0] r0, input logic [2:0] f0,
                      input logic [15:0] r1, input logic [2:0] f1);
    exp_t e;
    req_op = op; req_a = a; req_b = b; req_valid = 1'b1;
    for (int i = 0; i < 100 && !req_ready; i++) begin
      @(posedge clk); #1;
    end
    check("req_accept", {31'd0, req_ready}, 32'd1);
    e.r0 = r0; e.f0 = f0; e.r1 = r1; e.f1 = f1;
    e.lat = (op == 2'b11) ? 4 : 2;
    e.acc_cyc = cyc + 1;
    q.push_back(e);
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 100 && q.size() != 0; i++) begin
      @(posedge clk); #1;
    end
    check("drain", q.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    n_pass = 0; n_total = 0; cyc = 0; prev_valid = 1'b0;
    rst_n = 1'b0; req_valid = 1'b0; req_op = 2'b00; req_a = '0; req_b = '0; rsp_ready = 1'b1;

    vecs = '{
      '{2'b00, 16'h7FFF, 16'h0001, 16'h7FFF, 3'b010, 16'h8000, 3'b011},
      '{2'b01, 16'h8000, 16'h0001, 16'h8000, 3'b011, 16'h7FFF, 3'b010},
      '{2'b00, 16'h0005, 16'hFFFB, 16'h0000, 3'b100, 16'h0000, 3'b100},
      '{2'b01, 16'h0003, 16'h0005, 16'hFFFE, 3'b001, 16'hFFFE, 3'b001},
      '{2'b00, 16'h8000, 16'h8000, 16'h8000, 3'b011, 16'h0000, 3'b110},
      '{2'b10, 16'h7171, 16'h1818, 16'h7979, 3'b010, 16'h7979, 3'b010},
      '{2'b10, 16'h8888, 16'h8888, 16'h8888, 3'b011, 16'h8888, 3'b011},
      '{2'b11, 16'h1111, 16'h1111, 16'h0044, 3'b000, 16'h0044, 3'b000},
      '{2'b11, 16'h8080, 16'h8080, 16'hFE00, 3'b000, 16'hFE00, 3'b001},
      '{2'b11, 16'h7F80, 16'h01FF, 16'hFFFF, 3'b000, 16'hFFFF, 3'b001}
    };

    #12;
    check("rst_req_ready", {31'd0, req_ready}, 32'd1);
    check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_result", {16'd0, rsp_result}, 32'd0);
    check("rst_flags", {29'd0, rsp_flags}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    foreach (vecs[i])
      send(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].r0, vecs[i].f0, vecs[i].r1, vecs[i].f1);
    drain();

    // Backpressure: hold the response, offer a second request meanwhile.
    rsp_ready = 1'b0;
    send(2'b00, 16'h1234, 16'h1111, 16'h2345, 3'b000, 16'h2345, 3'b000);
    for (int i = 0; i < 20 && !rsp_valid; i++) begin
      @(posedge clk); #1;
    end
    req_op = 2'b01; req_a = 16'h0001; req_b = 16'h0001; req_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      check("bp_result", {16'd0, rsp_result}, 32'h2345);
      check("bp_flags", {29'd0, rsp_flags}, 32'd0);
      check("bp_req_ready", {31'd0, req_ready}, 32'd0);
      check("bp_rsp_valid", {31'd0, rsp_valid}, 32'd1);
      @(posedge clk); #1;
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_idle_ready", {31'd0, req_ready}, 32'd1);
    check("bp_idle_valid", {31'd0, rsp_valid}, 32'd0);
    send(2'b01, 16'h0001, 16'h0001, 16'h0000, 3'b100, 16'h0000, 3'b100);
    drain();

    // Leave a nonzero registered result, then reset in the middle of a RED.
    send(2'b11, 16'h8080, 16'h8080, 16'hFE00, 3'b000, 16'hFE00, 3'b001);
    drain();
    send(2'b11, 16'h0102, 16'h0304, 16'h000A, 3'b000, 16'h000A, 3'b000);
    @(posedge clk); #1;
    check("pre_rst_busy", {31'd0, busy}, 32'd1);
    check("pre_rst_result", {16'd0, alt_rsp_result}, 32'hFE00);
    rst_n = 1'b0;
    #1;
    check("arst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("arst_busy", {31'd0, busy}, 32'd0);
    check("arst_result", {16'd0, alt_rsp_result}, 32'd0);
    check("arst_flags", {29'd0, alt_rsp_flags}, 32'd0);
    q.delete();
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    check("post_rst_ready", {31'd0, req_ready}, 32'd1);
    send(2'b00, 16'h0002, 16'h0003, 16'h0005, 3'b000, 16'h0005, 3'b000);
    drain();

    @(posedge clk); #1;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
